spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
- Receiver end of the spike interface: consumes the 1-bit spike train produced by the team's LIF neuron and decodes it back into numbers.
- Counts spike events over consecutive, back-to-back windows of configurable length, and tracks the minimum inter-spike interval (ISI) within each window.
- Hands each window result to a downstream consumer over a valid/ready handshake.
- Sits between neuron outputs and the readout/host logic.

Parameters:
- CNT_W, 8: width of spike count; saturates at 2^CNT_W-1.
- WIN_W, 10: width of window length; window_len=0 means 2^WIN_W cycles.
- ISI_W, 8: width of ISI timer and min-ISI result; saturates at 2^ISI_W-1.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- enable  in  1  run decoder; low = idle, partial window discarded
- spike_in  in  1  spike train, synchronous to clk; may be held high several cycles
- window_len  in  WIN_W  window length in cycles, sampled at each window start
- out_ready  in  1  consumer accepts result
- out_valid  out  1  result pending
- out_count  out  CNT_W  spike events in window
- out_min_isi  out  ISI_W  minimum ISI in window; all-ones if fewer than 2 events
- overrun  out  1  sticky: a window result was dropped
- busy  out  1  high while in ACCUM

Behaviour:
- Reset (async): all registers to 0, except min_isi accumulator to all-ones.
  - State IDLE; out_valid=0, out_count=0, out_min_isi=0, overrun=0, busy=0, previous-spike register=0.
- Event definition: event = spike_in & ~spike_q (rising edge). A level held N cycles counts as 1 event.
- FSM: IDLE, ACCUM.
  - IDLE, enable=1: next cycle enter ACCUM. Latch win_len_q=window_len (0 -> 2^WIN_W). Clear counters. Clear overrun.
  - ACCUM, enable=0: next cycle IDLE. Partial window discarded. A pending output stays valid until accepted.
- Window timing:
  - win_cnt loads win_len_q-1 at window start and decrements each cycle.
  - The cycle with win_cnt==0 is the last window cycle; its event is included.
  - The next window starts the following cycle with no dead cycles, and window_len is resampled there.
- Count: increments on each event; saturates at 2^CNT_W-1.
- ISI tracking:
  - have_prev cleared at window start; ISIs never span windows.
  - isi_t resets to 1 on each event, else increments (saturating) each cycle.
  - On an event with have_prev=1: min_isi = min(min_isi, isi_t). Example: events at window cycles 2 and 5 give ISI 3.
  - min_isi resets to all-ones at window start.
- Commit (last window cycle), using final values including that cycle's event:
  - if out_valid=0, or out_valid&&out_ready that cycle: load out_count/out_min_isi; out_valid=1 next cycle (latency 1 after last window cycle).
  - if out_valid=1 and out_ready=0: new result dropped, old data held, overrun=1 (sticky).
- Handshake:
  - Data stable while out_valid=1 and not accepted.
  - On accept with no simultaneous commit, out_valid=0 next cycle.
  - out_ready is ignored while out_valid=0.
- enable drop on last window cycle: commit still happens, then IDLE.
- Reset mid-window: everything cleared immediately; no output produced.

Decomposition:
- Package spike_dec_pkg:
  - state enum {IDLE, ACCUM};
  - CNT_MAX and ISI_MAX constants;
  - saturating-increment function.
- One sub-module: spike_isi_tracker (edge detect, isi_t, have_prev, min_isi; window_start/window_end inputs).
- Top holds FSM, window counter, spike counter and output register/handshake.

Test Plan:
1. window_len=10, out_ready=1, single-cycle spikes at window cycles 1,4,9 -> out_count=3, out_min_isi=3, out_valid high exactly 1 cycle after window cycle 9.
2. window_len=10, spike_in held high cycles 2-6, no other spikes -> out_count=1, out_min_isi=255.
3. window_len=600, spike_in toggling every cycle (300 rising edges) -> out_count=255 (saturated), out_min_isi=2.
4. window_len=8, out_ready=0 across 2 windows -> first result held stable, overrun=1 after second window end; then out_ready=1 for 1 cycle -> out_valid=0 next cycle, overrun stays 1 until enable re-rise or reset.
5. out_ready=1 asserted exactly on a commit cycle with out_valid=1 -> old result accepted, new result loaded, out_valid stays 1, overrun=0.
6. Disable enable at window cycle 5 -> no result, busy=0 next cycle. Separately, assert reset mid-window -> all outputs 0 in same cycle, min_isi accumulator all-ones.

Source files
------------

// File: rtl/spike_dec_pkg.sv
// rtl/spike_dec_pkg.sv - shared state type, limits and saturating helper for the spike rate decoder
package spike_dec_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 10;
  localparam int DEF_ISI_W = 8;

  localparam int CNT_MAX = (1 << DEF_CNT_W) - 1;
  localparam int ISI_MAX = (1 << DEF_ISI_W) - 1;

  // Increment that sticks at lim instead of wrapping back to zero
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/spike_isi_tracker.sv
// rtl/spike_isi_tracker.sv - rising-edge event detect and minimum inter-spike interval per window
module spike_isi_tracker
  import spike_dec_pkg::*;
#(
  parameter int ISI_W = DEF_ISI_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike_in,
  input  logic             accum,         // a window is being accumulated this cycle
  input  logic             window_start,  // entering window cycle 0 from idle at the next edge
  input  logic             window_end,    // this is the last cycle of the current window
  output logic             event_o,       // rising edge of spike_in this cycle
  output logic [ISI_W-1:0] min_isi_now    // min ISI including this cycle's event
);

  localparam logic [31:0] ISI_LIM = 32'((64'd1 << ISI_W) - 64'd1);

  logic             spike_q, spike_d;
  logic             have_prev_q, have_prev_d;
  logic [ISI_W-1:0] isi_t_q, isi_t_d;
  logic [ISI_W-1:0] min_isi_q, min_isi_d;

  assign event_o = spike_in & ~spike_q;

  // Fold this cycle's interval into the running minimum, only once a prior event exists
  always_comb begin
    min_isi_now = min_isi_q;
    if (event_o && have_prev_q && (isi_t_q < min_isi_q)) begin
      min_isi_now = isi_t_q;
    end
  end

  // Next-state: clear on any window boundary, otherwise time intervals between events
  always_comb begin
    spike_d     = spike_in;
    have_prev_d = have_prev_q;
    isi_t_d     = isi_t_q;
    min_isi_d   = min_isi_q;
    if (window_start || window_end) begin
      have_prev_d = 1'b0;
      isi_t_d     = ISI_W'(1);
      min_isi_d   = '1;
    end else if (accum) begin
      min_isi_d = min_isi_now;
      if (event_o) begin
        have_prev_d = 1'b1;
        isi_t_d     = ISI_W'(1);
      end else begin
        isi_t_d = ISI_W'(sat_inc(32'(isi_t_q), ISI_LIM));
      end
    end
  end

  // Tracker registers; min_isi idles at all-ones so an empty window reads as "no interval"
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_q     <= 1'b0;
      have_prev_q <= 1'b0;
      isi_t_q     <= '0;
      min_isi_q   <= '1;
    end else begin
      spike_q     <= spike_d;
      have_prev_q <= have_prev_d;
      isi_t_q     <= isi_t_d;
      min_isi_q   <= min_isi_d;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed spike counter with min-ISI and valid/ready result output
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W,
  parameter int ISI_W = DEF_ISI_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] window_len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  output logic [ISI_W-1:0] out_min_isi,
  output logic             overrun,
  output logic             busy
);

  localparam logic [31:0] CNT_LIM = 32'((64'd1 << CNT_W) - 64'd1);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [ISI_W-1:0] out_min_isi_q, out_min_isi_d;
  logic             overrun_q, overrun_d;

  logic             in_accum;
  logic             window_start;
  logic             window_end;
  logic             spike_event;
  logic [CNT_W-1:0] count_now;
  logic [ISI_W-1:0] min_isi_now;

  assign in_accum     = (state_q == ACCUM);
  assign window_start = (state_q == IDLE) && enable;
  assign window_end   = in_accum && (win_cnt_q == '0);
  assign count_now    = spike_event ? CNT_W'(sat_inc(32'(count_q), CNT_LIM)) : count_q;

  spike_isi_tracker #(
    .ISI_W(ISI_W)
  ) u_isi (
    .clk         (clk),
    .reset       (reset),
    .spike_in    (spike_in),
    .accum       (in_accum),
    .window_start(window_start),
    .window_end  (window_end),
    .event_o     (spike_event),
    .min_isi_now (min_isi_now)
  );

  // FSM and window countdown; window_len minus one wraps so zero gives the full 2^WIN_W span
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = ACCUM;
          win_cnt_d = window_len - WIN_W'(1);
        end
      end
      ACCUM: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (window_end) begin
          win_cnt_d = window_len - WIN_W'(1);
        end else begin
          win_cnt_d = win_cnt_q - WIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-window event count, restarted at every window boundary
  always_comb begin
    count_d = count_q;
    if (window_start || window_end) begin
      count_d = '0;
    end else if (in_accum) begin
      count_d = count_now;
    end
  end

  // Result register: accept drains it, a commit refills it unless the old result is still unread
  always_comb begin
    out_valid_d   = out_valid_q;
    out_count_d   = out_count_q;
    out_min_isi_d = out_min_isi_q;
    overrun_d     = overrun_q;
    if (window_start) begin
      overrun_d = 1'b0;
    end
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (window_end) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d   = 1'b1;
        out_count_d   = count_now;
        out_min_isi_d = min_isi_now;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State, counters and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      win_cnt_q     <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      out_count_q   <= '0;
      out_min_isi_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      out_count_q   <= out_count_d;
      out_min_isi_q <= out_min_isi_d;
      overrun_q     <= overrun_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_count   = out_count_q;
  assign out_min_isi = out_min_isi_q;
  assign overrun     = overrun_q;
  assign busy        = in_accum;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - self-checking bench for spike_rate_decoder against a window-level model
module tb_spike_rate_decoder;
  import spike_dec_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       spike_in = 1'b0;
  logic [9:0] window_len = '0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_count;
  logic [7:0] out_min_isi;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;

  // model: window bookkeeping plus expected registered outputs (e_*) and their next values (n_*)
  bit m_active = 0;
  bit m_prev = 0;
  int m_pos = 0;
  int m_len = 0;
  int m_ev[$];
  int e_valid = 0, e_count = 0, e_min = 0, e_ovr = 0, e_busy = 0;
  int n_valid = 0, n_count = 0, n_min = 0, n_ovr = 0, n_busy = 0;

  spike_rate_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .spike_in   (spike_in),
    .window_len (window_len),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_count  (out_count),
    .out_min_isi(out_min_isi),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_active = 0; m_prev = 0; m_pos = 0; m_len = 0; m_ev.delete();
    e_valid = 0; e_count = 0; e_min = 0; e_ovr = 0; e_busy = 0;
  endfunction

  // One clock of the specification's rules: rising edges are events, results are
  // computed from the list of event positions in the window.
  function automatic void model_step(input bit en, input bit sp, input int wl, input bit rdy);
    bit ev, last;
    int rc, rm, d;
    ev = sp && !m_prev;
    m_prev = sp;
    n_valid = e_valid; n_count = e_count; n_min = e_min; n_ovr = e_ovr;
    if (e_valid != 0 && rdy) n_valid = 0;
    if (!m_active) begin
      if (en) begin
        m_active = 1; m_pos = 0; m_len = (wl == 0) ? 1024 : wl; m_ev.delete(); n_ovr = 0;
      end
    end else begin
      if (ev) m_ev.push_back(m_pos);
      last = (m_pos == m_len - 1);
      if (last) begin
        rc = (m_ev.size() > CNT_MAX) ? CNT_MAX : m_ev.size();
        rm = ISI_MAX;
        for (int i = 1; i < m_ev.size(); i++) begin
          d = m_ev[i] - m_ev[i-1];
          if (d < rm) rm = d;
        end
        if (e_valid == 0 || rdy) begin
          n_valid = 1; n_count = rc; n_min = rm;
        end else begin
          n_ovr = 1;
        end
      end
      if (!en) m_active = 0;
      else if (last) begin
        m_pos = 0; m_len = (wl == 0) ? 1024 : wl; m_ev.delete();
      end else m_pos++;
    end
    n_busy = m_active ? 1 : 0;
  endfunction

  // Drive one cycle of inputs, advance the model, land 1 time unit after the edge
  task automatic cycle(input bit en, input bit sp, input int wl, input bit rdy);
    enable = en; spike_in = sp; window_len = wl[9:0]; out_ready = rdy;
    model_step(en, sp, wl, rdy);
    @(posedge clk);
    #1;
    e_valid = n_valid; e_count = n_count; e_min = n_min; e_ovr = n_ovr; e_busy = n_busy;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; spike_in = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(out_count), 0);
    chk("rst_min", 32'(out_min_isi), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_min_acc", 32'(dut.u_isi.min_isi_q), 255);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), e_valid);
    chk("out_count", 32'(out_count), e_count);
    chk("out_min_isi", 32'(out_min_isi), e_min);
    chk("overrun", 32'(overrun), e_ovr);
    chk("busy", 32'(busy), e_busy);
  end

  initial begin
    bit sp;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // 1: spikes at window cycles 1,4,9
    cycle(1, 0, 10, 1);
    for (int k = 0; k < 10; k++) begin
      cycle(1, (k == 1 || k == 4 || k == 9), 10, 1);
      if (k == 8) chk("t1_valid_early", 32'(out_valid), 0);
    end
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_count", 32'(out_count), 3);
    chk("t1_min", 32'(out_min_isi), 3);
    chk("t1_model_min", e_min, 3);
    cycle(0, 0, 10, 1);

    // 2: level held cycles 2..6 is one event
    do_reset();
    cycle(1, 0, 10, 1);
    for (int k = 0; k < 10; k++) cycle(1, (k >= 2 && k <= 6), 10, 1);
    chk("t2_count", 32'(out_count), 1);
    chk("t2_min", 32'(out_min_isi), 255);

    // 3: toggling for 600 cycles saturates the count
    do_reset();
    cycle(1, 0, 600, 1);
    for (int k = 0; k < 600; k++) cycle(1, k[0], 600, 1);
    chk("t3_count", 32'(out_count), 255);
    chk("t3_min", 32'(out_min_isi), 2);
    chk("t3_model_count", e_count, 255);

    // 4: unread result held across a second window, overrun sticky until re-enable
    do_reset();
    cycle(1, 0, 8, 0);
    for (int k = 0; k < 8; k++) cycle(1, (k == 3), 8, 0);
    chk("t4_valid1", 32'(out_valid), 1);
    chk("t4_count1", 32'(out_count), 1);
    chk("t4_ovr1", 32'(overrun), 0);
    for (int k = 0; k < 8; k++) cycle(1, (k == 1 || k == 5), 8, 0);
    chk("t4_count_held", 32'(out_count), 1);
    chk("t4_min_held", 32'(out_min_isi), 255);
    chk("t4_ovr2", 32'(overrun), 1);
    cycle(1, 0, 8, 1);
    chk("t4_drained", 32'(out_valid), 0);
    chk("t4_ovr_sticky", 32'(overrun), 1);
    cycle(0, 0, 8, 0);
    chk("t4_ovr_idle", 32'(overrun), 1);
    cycle(1, 0, 8, 0);
    chk("t4_ovr_clear", 32'(overrun), 0);

    // 5: accept on the commit cycle swaps results without overrun
    do_reset();
    cycle(1, 0, 8, 0);
    for (int k = 0; k < 8; k++) cycle(1, (k == 2), 8, 0);
    for (int k = 0; k < 8; k++) cycle(1, (k == 0 || k == 3 || k == 6), 8, (k == 7));
    chk("t5_valid", 32'(out_valid), 1);
    chk("t5_count", 32'(out_count), 3);
    chk("t5_min", 32'(out_min_isi), 3);
    chk("t5_ovr", 32'(overrun), 0);

    // 6a: disable mid-window discards the partial result
    do_reset();
    cycle(1, 0, 10, 1);
    for (int k = 0; k < 5; k++) cycle(1, k[0], 10, 1);
    cycle(0, 1, 10, 1);
    chk("t6_busy", 32'(busy), 0);
    for (int k = 0; k < 12; k++) cycle(0, 0, 10, 1);
    chk("t6_no_result", 32'(out_valid), 0);

    // 6b: reset mid-window with a pending result clears everything at once
    cycle(1, 0, 4, 0);
    for (int k = 0; k < 4; k++) cycle(1, (k == 1), 4, 0);
    for (int k = 0; k < 2; k++) cycle(1, (k == 0), 4, 0);
    chk("t6_pending", 32'(out_valid), 1);
    do_reset();

    // randomized traffic
    sp = 0;
    for (int c = 0; c < 6000; c++) begin
      int wl;
      bit en;
      if ($urandom_range(0, 2) == 0) sp = ~sp;
      wl = ($urandom_range(0, 60) == 0) ? 0 : int'($urandom_range(1, 12));
      en = ($urandom_range(0, 150) != 0);
      cycle(en, sp, wl, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2500) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
